regfile_wb_arbiter: RTL and testbench

//   Shares the register file's single write port among NREQ write-back requesters (ALU, LSU, MDU).

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_rr.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and payload types for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NREG    = 1 << REG_AW;
  localparam int unsigned NUM_REQ = 3;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MDU = 2;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: scans upward from the pointer, one grant per cycle.
module rr_arbiter #(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant_c,
  output logic [IW-1:0] o_grant_idx_c,
  output logic          o_grant_vld_c,
  output logic [IW-1:0] o_ptr
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic          w_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else        r_ptr <= w_ptr_nxt;
  end

  // First valid requester at or above the pointer (wrapping) wins.
  always_comb begin
    int unsigned j;
    w_grant   = '0;
    w_idx     = '0;
    w_vld     = 1'b0;
    w_ptr_nxt = r_ptr;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_vld && i_req[IW'(j)]) begin
        w_vld            = 1'b1;
        w_grant[IW'(j)]  = 1'b1;
        w_idx            = IW'(j);
      end
    end
    if (w_vld) w_ptr_nxt = (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
  end

  assign o_grant_c     = w_grant;
  assign o_grant_idx_c = w_idx;
  assign o_grant_vld_c = w_vld;
  assign o_ptr         = r_ptr;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among write-back units and tracks
// outstanding destination registers for read-after-write hazard detection.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = regfile_wb_arbiter_pkg::NUM_REQ,
  parameter int unsigned XLEN = regfile_wb_arbiter_pkg::XLEN,
  parameter int unsigned AW   = regfile_wb_arbiter_pkg::REG_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*AW-1:0]   i_req_wa,
  input  logic [NREQ*XLEN-1:0] i_req_wd,
  output logic [NREQ-1:0]      o_req_ready_c,
  input  logic                 i_issue_en,
  input  logic [AW-1:0]        i_issue_rd,
  input  logic [AW-1:0]        i_ra1,
  input  logic [AW-1:0]        i_ra2,
  output logic                 o_hazard_c,
  output logic                 o_we3,
  output logic [AW-1:0]        o_wa3,
  output logic [XLEN-1:0]      o_wd3,
  output logic [(1<<AW)-1:0]   o_pending
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = 1 << AW;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  logic [IW-1:0]   w_rr_ptr;
  logic            w_gvld;
  logic            w_hs;
  logic            w_wr;
  logic [AW-1:0]   w_sel_wa;
  logic [XLEN-1:0] w_sel_wd;

  logic            r_we;
  logic [AW-1:0]   r_wa;
  logic [XLEN-1:0] r_wd;
  logic [NR-1:0]   r_pending;
  logic [NR-1:0]   w_pend_nxt;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (i_req_valid),
    .o_grant_c     (w_grant),
    .o_grant_idx_c (w_gidx),
    .o_grant_vld_c (w_gvld),
    .o_ptr         (w_rr_ptr)
  );

  // Grants are suppressed while reset is asserted so no handshake can complete.
  assign o_req_ready_c = rst_n ? w_grant : '0;
  assign w_hs          = rst_n & w_gvld;

  always_comb begin
    w_sel_wa = '0;
    w_sel_wd = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == w_gidx) begin
        w_sel_wa = i_req_wa[i*AW +: AW];
        w_sel_wd = i_req_wd[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 are acknowledged but never reach the register file.
  assign w_wr = w_hs && (w_sel_wa != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_wa <= w_sel_wa;
        r_wd <= w_sel_wd;
      end
    end
  end

  // Retire on the RF write edge; a same-edge new producer keeps the bit set.
  always_comb begin
    w_pend_nxt = r_pending;
    if (r_we) w_pend_nxt[r_wa] = 1'b0;
    if (i_issue_en && (i_issue_rd != '0)) w_pend_nxt[i_issue_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pend_nxt;
  end

  assign o_hazard_c = ((i_ra1 != '0)      & r_pending[i_ra1])
                    | ((i_ra2 != '0)      & r_pending[i_ra2])
                    | ((i_issue_rd != '0) & r_pending[i_issue_rd]);

  assign o_we3     = r_we;
  assign o_wa3     = r_wa;
  assign o_wd3     = r_wd;
  assign o_pending = r_pending;

  a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
    32'(w_rr_ptr) < NREQ);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write-back scoreboard.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int unsigned AW = REG_AW;
  localparam int unsigned NQ = NUM_REQ;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NQ-1:0]      i_req_valid;
  logic [NQ*AW-1:0]   i_req_wa;
  logic [NQ*XLEN-1:0] i_req_wd;
  logic [NQ-1:0]      o_req_ready_c;
  logic               i_issue_en;
  logic [AW-1:0]      i_issue_rd;
  logic [AW-1:0]      i_ra1;
  logic [AW-1:0]      i_ra2;
  logic               o_hazard_c;
  logic               o_we3;
  logic [AW-1:0]      o_wa3;
  logic [XLEN-1:0]    o_wd3;
  logic [NREG-1:0]    o_pending;

  regfile_wb_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (i_req_valid),
    .i_req_wa      (i_req_wa),
    .i_req_wd      (i_req_wd),
    .o_req_ready_c (o_req_ready_c),
    .i_issue_en    (i_issue_en),
    .i_issue_rd    (i_issue_rd),
    .i_ra1         (i_ra1),
    .i_ra2         (i_ra2),
    .o_hazard_c    (o_hazard_c),
    .o_we3         (o_we3),
    .o_wa3         (o_wa3),
    .o_wd3         (o_wd3),
    .o_pending     (o_pending)
  );

  always #5 clk = ~clk;

  int      vectors     = 0;
  int      miscompares = 0;
  wb_req_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic wb_req_t mk(input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
    wb_req_t w;
    w.wa = wa;
    w.wd = wd;
    return w;
  endfunction

  function automatic logic [XLEN-1:0] rr_wd(input int g, input int r);
    return 32'hC000_0000 | XLEN'(g << 8) | XLEN'(r);
  endfunction

  task automatic set_req(input int g, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
    i_req_wa[g*AW +: AW]     = wa;
    i_req_wd[g*XLEN +: XLEN] = wd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    i_req_valid = '0;
    i_issue_en  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wb_unexpected: got write wa=%0d wd=%h, expected no write", o_wa3, o_wd3);
      end else begin
        wb_req_t w;
        w = exp_q.pop_front();
        chk("wb_write", 64'({o_wa3, o_wd3}), 64'({w.wa, w.wd}));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n       = 1'b1;
    i_req_valid = '0;
    i_req_wa    = '0;
    i_req_wd    = '0;
    i_issue_en  = 1'b0;
    i_issue_rd  = '0;
    i_ra1       = '0;
    i_ra2       = '0;
    #1 rst_n = 1'b0;
    i_req_valid = 3'b111;
    #1;
    chk("rst_we3",     64'(o_we3),         64'(0));
    chk("rst_wa3",     64'(o_wa3),         64'(0));
    chk("rst_pending", 64'(o_pending),     64'(0));
    chk("rst_ready",   64'(o_req_ready_c), 64'(0));
    @(negedge clk);
    rst_n       = 1'b1;
    i_req_valid = '0;
    cyc();

    // Reset dropped while a write is being presented
    i_issue_en = 1'b1;
    i_issue_rd = 5'd9;
    set_req(REQ_ALU, 5'd9, 32'hAAAA_5555);
    i_req_valid = 3'b001;
    neg();
    chk("t1_ready", 64'(o_req_ready_c), 64'(3'b001));
    cyc();
    i_issue_en  = 1'b0;
    i_req_valid = '0;
    #1;
    chk("t1_we3_pre",  64'(o_we3),     64'(1));
    chk("t1_wa3_pre",  64'(o_wa3),     64'(9));
    chk("t1_pend_pre", 64'(o_pending), 64'(32'h0000_0200));
    set_req(REQ_LSU, 5'd3, 32'h1);
    i_req_valid = 3'b010;
    rst_n       = 1'b0;
    #1;
    chk("t1_we3_rst",   64'(o_we3),         64'(0));
    chk("t1_pend_rst",  64'(o_pending),     64'(0));
    chk("t1_ready_rst", 64'(o_req_ready_c), 64'(0));
    @(negedge clk);
    rst_n       = 1'b1;
    i_req_valid = '0;
    cyc();

    // Basic path: issue, hazard, write, retire
    i_issue_en = 1'b1;
    i_issue_rd = 5'd5;
    cyc();
    i_issue_en = 1'b0;
    i_issue_rd = 5'd0;
    i_ra1      = 5'd5;
    set_req(REQ_ALU, 5'd5, 32'hDEAD_BEEF);
    i_req_valid = 3'b001;
    exp_q.push_back(mk(5'd5, 32'hDEAD_BEEF));
    neg();
    chk("t2_hazard_ra1", 64'(o_hazard_c),    64'(1));
    chk("t2_ready",      64'(o_req_ready_c), 64'(3'b001));
    cyc();
    i_req_valid = '0;
    neg();
    chk("t2_we3",      64'(o_we3),        64'(1));
    chk("t2_pend_n1",  64'(o_pending[5]), 64'(1));
    chk("t2_haz_n1",   64'(o_hazard_c),   64'(1));
    cyc();
    neg();
    chk("t2_pend_n2",  64'(o_pending[5]), 64'(0));
    chk("t2_haz_n2",   64'(o_hazard_c),   64'(0));
    i_ra1 = 5'd0;

    // Round-robin with all requesters continuously valid
    do_reset();
    for (int g = 0; g < 3; g++) set_req(g, AW'(g + 1), rr_wd(g, 0));
    for (int k = 0; k < 6; k++) exp_q.push_back(mk(AW'(k % 3 + 1), rr_wd(k % 3, k / 3)));
    i_req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      neg();
      chk("t3_ready", 64'(o_req_ready_c), 64'(1 << (k % 3)));
      if (k > 0) chk("t3_we3_pulse", 64'(o_we3), 64'(1));
      cyc();
      set_req(k % 3, AW'(k % 3 + 1), rr_wd(k % 3, k / 3 + 1));
    end
    i_req_valid = '0;
    neg();
    cyc();
    neg();
    chk("t3_we3_idle", 64'(o_we3), 64'(0));
    cyc();

    // x0 write squashed; issue to x0 leaves the scoreboard alone
    set_req(REQ_LSU, 5'd0, 32'h0000_1234);
    i_req_valid = 3'b010;
    i_issue_en  = 1'b1;
    i_issue_rd  = 5'd3;
    neg();
    chk("t4_ready", 64'(o_req_ready_c), 64'(3'b010));
    cyc();
    i_req_valid = '0;
    i_issue_rd  = 5'd0;
    neg();
    chk("t4_we3_x0",  64'(o_we3),     64'(0));
    chk("t4_pend_3",  64'(o_pending), 64'(32'h0000_0008));
    cyc();
    i_issue_en = 1'b0;
    neg();
    chk("t4_pend_x0", 64'(o_pending), 64'(32'h0000_0008));
    i_issue_rd = 5'd3;
    #1;
    chk("t4_haz_issue_rd", 64'(o_hazard_c), 64'(1));
    cyc();
    i_issue_rd = 5'd0;

    // Same-edge retire and reissue of x7
    i_issue_en = 1'b1;
    i_issue_rd = 5'd7;
    cyc();
    i_issue_en = 1'b0;
    set_req(REQ_ALU, 5'd7, 32'h0000_7777);
    i_req_valid = 3'b001;
    exp_q.push_back(mk(5'd7, 32'h0000_7777));
    neg();
    chk("t5_ready", 64'(o_req_ready_c), 64'(3'b001));
    cyc();
    i_req_valid = '0;
    i_issue_en  = 1'b1;
    i_issue_rd  = 5'd7;
    neg();
    chk("t5_we3", 64'(o_we3), 64'(1));
    chk("t5_wa3", 64'(o_wa3), 64'(7));
    cyc();
    i_issue_en = 1'b0;
    i_issue_rd = 5'd0;
    neg();
    chk("t5_pend_setwins", 64'(o_pending[7]), 64'(1));
    cyc();
    set_req(REQ_ALU, 5'd7, 32'h0000_7778);
    i_req_valid = 3'b001;
    exp_q.push_back(mk(5'd7, 32'h0000_7778));
    neg();
    chk("t5_ready2", 64'(o_req_ready_c), 64'(3'b001));
    cyc();
    i_req_valid = '0;
    neg();
    cyc();
    neg();
    chk("t5_pend_clear", 64'(o_pending[7]), 64'(0));
    cyc();

    // RA2 hazard while MDU waits behind ALU and LSU
    do_reset();
    i_issue_en = 1'b1;
    i_issue_rd = 5'd12;
    cyc();
    i_issue_en = 1'b0;
    neg();
    chk("t6_haz_rd", 64'(o_hazard_c), 64'(1));
    cyc();
    i_issue_rd = 5'd0;
    i_ra2      = 5'd12;
    set_req(REQ_ALU, 5'd20, 32'h0000_2020);
    set_req(REQ_LSU, 5'd21, 32'h0000_2121);
    set_req(REQ_MDU, 5'd12, 32'hCAFE_F00D);
    i_req_valid = 3'b111;
    exp_q.push_back(mk(5'd20, 32'h0000_2020));
    exp_q.push_back(mk(5'd21, 32'h0000_2121));
    exp_q.push_back(mk(5'd12, 32'hCAFE_F00D));
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("t6_ready",  64'(o_req_ready_c), 64'(1 << k));
      chk("t6_haz_ra2", 64'(o_hazard_c),   64'(1));
      cyc();
      i_req_valid[k] = 1'b0;
    end
    neg();
    chk("t6_wa3_mdu",  64'(o_wa3),      64'(12));
    chk("t6_haz_wr",   64'(o_hazard_c), 64'(1));
    cyc();
    neg();
    chk("t6_haz_clear", 64'(o_hazard_c), 64'(0));
    i_ra2 = 5'd0;

    repeat (3) cyc();
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
